// File: rtl/sr_writer_pkg.sv
// Shared types and default sizing for the SR-bank write controller.
package sr_writer_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 8;
    localparam int unsigned DEFAULT_MAX_RETRY = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/sr_excite.sv
// Minimal SR excitation: only masked bits that differ from the target get
// exactly one of S or R, so S and R are never high together.
module sr_excite #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);

    assign s = mask &  data & ~q;
    assign r = mask & ~data &  q;

endmodule

// File: rtl/sr_bank_writer.sv
// Write controller for an SR-cell bank: drive minimal excitation for one
// cycle, read Q back, retry on mismatch and latch a sticky error when out of retries.
module sr_bank_writer
    import sr_writer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_RETRY = DEFAULT_MAX_RETRY
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic [WIDTH-1:0]                   in_mask,
    input  logic [WIDTH-1:0]                   q_in,
    output logic [WIDTH-1:0]                   s_out,
    output logic [WIDTH-1:0]                   r_out,
    output logic                               done,
    output logic                               err,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

    localparam int unsigned CW = $clog2(MAX_RETRY + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] msk_q, msk_d;
    logic [WIDTH-1:0] s_d, r_d;
    logic             done_d, err_d, ready_d;
    logic [CW-1:0]    cnt_d;

    logic [WIDTH-1:0] ex_data, ex_mask, ex_s, ex_r;
    logic             match;

    // The first drive uses the incoming request; retries use the latched copy.
    assign ex_data = (state_q == IDLE) ? in_data : tgt_q;
    assign ex_mask = (state_q == IDLE) ? in_mask : msk_q;
    assign match   = ((q_in ^ tgt_q) & msk_q) == '0;

    sr_excite #(.WIDTH(WIDTH)) u_excite (
        .data (ex_data),
        .mask (ex_mask),
        .q    (q_in),
        .s    (ex_s),
        .r    (ex_r)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        msk_d   = msk_q;
        s_d     = '0;
        r_d     = '0;
        done_d  = 1'b0;
        err_d   = err;
        cnt_d   = retry_cnt;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    tgt_d   = in_data;
                    msk_d   = in_mask;
                    s_d     = ex_s;
                    r_d     = ex_r;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = DRIVE;
                end
            end
            DRIVE: state_d = CHECK;
            CHECK: begin
                if (match) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else if (retry_cnt < CW'(MAX_RETRY)) begin
                    cnt_d   = retry_cnt + CW'(1);
                    s_d     = ex_s;
                    r_d     = ex_r;
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            ERR:     err_d   = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            msk_q     <= '0;
            s_out     <= '0;
            r_out     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            retry_cnt <= '0;
            in_ready  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            msk_q     <= msk_d;
            s_out     <= s_d;
            r_out     <= r_d;
            done      <= done_d;
            err       <= err_d;
            retry_cnt <= cnt_d;
            in_ready  <= ready_d;
        end
    end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Directed and random checks of sr_bank_writer against a behavioural SR bank
// and a scoreboard of masked targets.
module tb_sr_bank_writer;

    localparam int unsigned W  = 8;
    localparam int unsigned MR = 3;

    typedef struct {
        logic [W-1:0] tgt;
        logic [W-1:0] mask;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data, in_mask;
    logic [W-1:0] q_in;
    logic [W-1:0] s_out, r_out;
    logic         done, err;
    logic [1:0]   retry_cnt;

    logic [W-1:0] bank_q = '0;
    logic [W-1:0] stuck0 = '0;
    logic         bank_ld = 1'b0;
    logic [W-1:0] bank_ld_val = '0;
    logic         mon_en = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    exp_t sb[$];

    sr_bank_writer #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .q_in      (q_in),
        .s_out     (s_out),
        .r_out     (r_out),
        .done      (done),
        .err       (err),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    assign q_in = bank_q;

    // SR bank with optional stuck-at-0 cells; load port lets the bench preset Q.
    always @(posedge clk) begin
        if (bank_ld) bank_q <= bank_ld_val;
        else         bank_q <= ((bank_q | s_out) & ~r_out) & ~stuck0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) chk("s_and_r_exclusive", 32'(s_out & r_out), 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bank_set(input logic [W-1:0] v);
        bank_ld     = 1'b1;
        bank_ld_val = v;
        tick();
        bank_ld     = 1'b0;
    endtask

    // Issue one request; report cycles from accept to done/err and drive cycles seen.
    task automatic do_req(input logic [W-1:0] d, input logic [W-1:0] m,
                          output int lat, output int nexc, output bit saw_err);
        logic [W-1:0] exp_s, exp_r;
        exp_t e;
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        chk("ready_before_req", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        exp_s    = m & d & ~bank_q;
        exp_r    = m & ~d & bank_q;
        sb.push_back('{tgt: d & m, mask: m});
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_mask  = W'($urandom);
        chk("s_first_drive", 32'(s_out), 32'(exp_s));
        chk("r_first_drive", 32'(r_out), 32'(exp_r));
        lat     = -1;
        nexc    = 0;
        saw_err = 1'b0;
        for (int k = 0; k <= 2 * (MR + 1) + 4; k++) begin
            if (k > 0) tick();
            chk("unmasked_untouched", 32'((s_out | r_out) & ~m), 32'h0);
            if ((s_out | r_out) != '0) nexc++;
            if (done) begin
                lat = k;
                e = sb.pop_front();
                chk("done_masked_q", 32'(q_in & e.mask), 32'(e.tgt));
                break;
            end
            if (err) begin
                lat = k;
                void'(sb.pop_front());
                saw_err = 1'b1;
                break;
            end
        end
        if (lat < 0) chk("req_timeout", 32'h1, 32'h0);
    endtask

    initial begin
        int lat, nexc;
        bit e;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_mask  = '0;
        bank_set(8'h00);
        tick();
        chk("rst_s_out", 32'(s_out), 32'h0);
        chk("rst_r_out", 32'(r_out), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_retry_cnt", 32'(retry_cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();
        chk("ready_after_rst", 32'(in_ready), 32'h1);

        // 0x00 -> 0xA5, full mask
        do_req(8'hA5, 8'hFF, lat, nexc, e);
        chk("a5_latency", 32'(lat), 32'h2);
        chk("a5_err", 32'(e), 32'h0);
        chk("a5_retry_cnt", 32'(retry_cnt), 32'h0);
        chk("a5_bank", 32'(bank_q), 32'hA5);

        // 0xA5 -> 0x3C: expect S=0x18, R=0x81
        do_req(8'h3C, 8'hFF, lat, nexc, e);
        chk("3c_latency", 32'(lat), 32'h2);
        chk("3c_bank", 32'(bank_q), 32'h3C);

        // Partial mask: only the low nibble is written
        bank_set(8'h00);
        do_req(8'hFF, 8'h0F, lat, nexc, e);
        chk("nib_latency", 32'(lat), 32'h2);
        chk("nib_bank", 32'(bank_q), 32'h0F);

        // Empty mask: no excitation, same latency
        do_req(8'hFF, 8'h00, lat, nexc, e);
        chk("nomask_latency", 32'(lat), 32'h2);
        chk("nomask_drives", 32'(nexc), 32'h0);
        chk("nomask_bank", 32'(bank_q), 32'h0F);

        // Stuck cell exhausts retries
        stuck0 = 8'h01;
        bank_set(8'h00);
        do_req(8'h01, 8'hFF, lat, nexc, e);
        chk("stuck_err_seen", 32'(e), 32'h1);
        chk("stuck_err_latency", 32'(lat), 32'(2 * (MR + 1)));
        chk("stuck_drive_cycles", 32'(nexc), 32'(MR + 1));
        chk("stuck_retry_cnt", 32'(retry_cnt), 32'(MR));
        for (int i = 0; i < 3; i++) tick();
        chk("stuck_ready_low", 32'(in_ready), 32'h0);
        chk("stuck_err_sticky", 32'(err), 32'h1);
        chk("stuck_s_zero", 32'(s_out), 32'h0);
        rst = 1'b1;
        tick();
        chk("stuck_rst_err", 32'(err), 32'h0);
        chk("stuck_rst_retry", 32'(retry_cnt), 32'h0);
        rst    = 1'b0;
        stuck0 = 8'h00;
        tick();
        chk("stuck_ready_after_rst", 32'(in_ready), 32'h1);

        // Reset during DRIVE abandons the request
        bank_set(8'h00);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_mask  = 8'hFF;
        tick();
        in_valid = 1'b0;
        chk("middrive_s", 32'(s_out), 32'hFF);
        rst = 1'b1;
        tick();
        chk("middrive_s_dropped", 32'(s_out), 32'h0);
        chk("middrive_no_done", 32'(done), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("middrive_no_done_later", 32'(done), 32'h0);
        end
        chk("middrive_ready", 32'(in_ready), 32'h1);

        // Random requests against a random bank
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) bank_set(W'($urandom));
            do_req(W'($urandom), W'($urandom), lat, nexc, e);
            chk("rand_latency", 32'(lat), 32'h2);
            chk("rand_err", 32'(e), 32'h0);
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
